// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and the load/store path.
// Data has priority; a starvation counter forces a fetch grant after STARVE_LIMIT lost arbitrations.
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [3:0]        d_be,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_be,
   input  logic              mem_ready,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   logic [1:0]        state_reg;
   logic [3:0]        starve_cnt_reg;
   logic              owner_fetch_reg;
   logic              drop_reg;
   logic              mem_req_reg;
   logic              mem_we_reg;
   logic [ADDR_W-1:0] mem_addr_reg;
   logic [DATA_W-1:0] mem_wdata_reg;
   logic [3:0]        mem_be_reg;
   logic              if_rvalid_reg;
   logic [DATA_W-1:0] if_rdata_reg;
   logic              d_rvalid_reg;
   logic [DATA_W-1:0] d_rdata_reg;

   logic fetch_wins;
   logic data_wins;

   // Grants are combinational so the requester can drop its request on the next edge.
   always_comb begin
      fetch_wins = 1'b0;
      data_wins  = 1'b0;
      if (!reset && state_reg == ST_IDLE) begin
         if (if_req && (!d_req || starve_cnt_reg == STARVE_MAX)) begin
            fetch_wins = 1'b1;
         end else if (d_req) begin
            data_wins = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= ST_IDLE;
         starve_cnt_reg  <= '0;
         owner_fetch_reg <= 1'b0;
         drop_reg        <= 1'b0;
         mem_req_reg     <= 1'b0;
         mem_we_reg      <= 1'b0;
         mem_addr_reg    <= '0;
         mem_wdata_reg   <= '0;
         mem_be_reg      <= '0;
         if_rvalid_reg   <= 1'b0;
         if_rdata_reg    <= '0;
         d_rvalid_reg    <= 1'b0;
         d_rdata_reg     <= '0;
      end else begin
         if_rvalid_reg <= 1'b0;
         d_rvalid_reg  <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (fetch_wins) begin
                  state_reg       <= ST_ISSUE;
                  mem_req_reg     <= 1'b1;
                  owner_fetch_reg <= 1'b1;
                  drop_reg        <= if_flush;
                  mem_we_reg      <= 1'b0;
                  mem_addr_reg    <= if_addr;
                  mem_wdata_reg   <= '0;
                  mem_be_reg      <= 4'hF;
                  starve_cnt_reg  <= '0;
               end else if (data_wins) begin
                  state_reg       <= ST_ISSUE;
                  mem_req_reg     <= 1'b1;
                  owner_fetch_reg <= 1'b0;
                  drop_reg        <= 1'b0;
                  mem_we_reg      <= d_we;
                  mem_addr_reg    <= d_addr;
                  mem_wdata_reg   <= d_wdata;
                  mem_be_reg      <= d_be;
                  if (if_req && starve_cnt_reg < STARVE_MAX) begin
                     starve_cnt_reg <= starve_cnt_reg + 4'd1;
                  end
               end
            end
            ST_ISSUE: begin
               if (owner_fetch_reg && if_flush) begin
                  drop_reg <= 1'b1;
               end
               if (mem_ready) begin
                  mem_req_reg <= 1'b0;
                  state_reg   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (mem_rvalid) begin
                  state_reg <= ST_IDLE;
                  // A flush arriving with the memory response still kills the fetch.
                  if (owner_fetch_reg) begin
                     if (!drop_reg && !if_flush) begin
                        if_rvalid_reg <= 1'b1;
                        if_rdata_reg  <= mem_rdata;
                     end
                  end else begin
                     d_rvalid_reg <= 1'b1;
                     d_rdata_reg  <= mem_we_reg ? '0 : mem_rdata;
                  end
               end else if (owner_fetch_reg && if_flush) begin
                  drop_reg <= 1'b1;
               end
            end
            default: begin
               state_reg   <= ST_IDLE;
               mem_req_reg <= 1'b0;
            end
         endcase
      end
   end

   assign if_gnt    = fetch_wins;
   assign d_gnt     = data_wins;
   assign if_rvalid = if_rvalid_reg;
   assign if_rdata  = if_rdata_reg;
   assign d_rvalid  = d_rvalid_reg;
   assign d_rdata   = d_rdata_reg;
   assign mem_req   = mem_req_reg;
   assign mem_we    = mem_we_reg;
   assign mem_addr  = mem_addr_reg;
   assign mem_wdata = mem_wdata_reg;
   assign mem_be    = mem_be_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed latency/backpressure/reset checks, then
// randomized traffic against a transaction-level reference with a response scoreboard.
module tb_mem_port_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SL = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic          if_flush = 1'b0;
   logic          if_gnt, if_rvalid;
   logic [DW-1:0] if_rdata;
   logic          d_req = 1'b0, d_we = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic [3:0]    d_be = '0;
   logic          d_gnt, d_rvalid;
   logic [DW-1:0] d_rdata;
   logic          mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [3:0]    mem_be;
   logic          mem_ready = 1'b0, mem_rvalid = 1'b0;
   logic [DW-1:0] mem_rdata = '0;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;
   bit sb_on = 1'b0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endfunction

   typedef struct {
      logic          fetch;
      logic [DW-1:0] data;
      int            due;
   } exp_t;
   exp_t exp_q[$];

   // Reference memory (expected values) and the memory macro the bench answers from.
   logic [DW-1:0] ref_mem [16];
   logic [DW-1:0] mac_mem [16];

   // Transaction-level reference state
   int            m_phase;   // 0 free, 1 request presented, 2 awaiting response
   logic          m_fetch, m_drop, m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_exp_data, rv_data;
   logic [3:0]    m_be;
   int            m_starve, rv_cnt;
   bit            if_done, d_done;

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                           input logic [3:0] be);
      logic [DW-1:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
      return r;
   endfunction

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1; if_req = 0; d_req = 0; if_flush = 0; mem_ready = 0; mem_rvalid = 0;
      @(posedge clk); #1;
      reset = 1'b0;
      m_phase = 0; m_starve = 0; m_drop = 0; m_fetch = 0; rv_cnt = 0;
      if_done = 0; d_done = 0;
   endtask

   task automatic step(input int p_if, input int p_d, input int p_rdy, input int p_fl);
      bit gf, gd, rv_fire;
      int start_phase;
      @(posedge clk); #1;
      if (if_done) begin if_req = 0; if_done = 0; end
      if (d_done)  begin d_req = 0;  d_done = 0;  end
      if (!if_req && $urandom_range(0, 99) < p_if) begin
         if_req = 1; if_addr = $urandom() & 32'hFFFF_FFFC;
      end
      if (!d_req && $urandom_range(0, 99) < p_d) begin
         d_req = 1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom() & 32'hFFFF_FFFC;
         d_wdata = $urandom(); d_be = 4'($urandom_range(0, 15));
      end
      if_flush  = ($urandom_range(0, 99) < p_fl);
      mem_ready = ($urandom_range(0, 99) < p_rdy);
      mem_rvalid = 0; mem_rdata = $urandom(); rv_fire = 0;
      if (m_phase == 2) begin
         if (rv_cnt == 0) begin mem_rvalid = 1; mem_rdata = rv_data; rv_fire = 1; end
         else rv_cnt--;
      end
      #1;
      start_phase = m_phase;
      gf = 0; gd = 0;
      if (start_phase == 0) begin
         if (if_req && (!d_req || m_starve == SL)) gf = 1;
         else if (d_req) gd = 1;
      end
      chk("if_gnt", 64'(if_gnt), 64'(gf));
      chk("d_gnt", 64'(d_gnt), 64'(gd));
      chk("mem_req", 64'(mem_req), 64'(start_phase == 1));
      if (start_phase != 0 && m_fetch && if_flush) m_drop = 1;
      if (start_phase == 1 && mem_ready) begin
         chk("mem_addr", 64'(mem_addr), 64'(m_addr));
         chk("mem_we", 64'(mem_we), 64'(m_we));
         chk("mem_be", 64'(mem_be), 64'(m_be));
         chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
         rv_data = mem_we ? $urandom() : mac_mem[mem_addr[5:2]];
         if (mem_we) mac_mem[mem_addr[5:2]] = merge(mac_mem[mem_addr[5:2]], mem_wdata, mem_be);
         m_exp_data = m_we ? '0 : ref_mem[m_addr[5:2]];
         if (m_we) ref_mem[m_addr[5:2]] = merge(ref_mem[m_addr[5:2]], m_wdata, m_be);
         m_phase = 2; rv_cnt = $urandom_range(0, 2);
      end else if (start_phase == 2 && rv_fire) begin
         if (!m_drop) exp_q.push_back('{fetch: m_fetch, data: m_exp_data, due: cyc + 1});
         m_phase = 0;
      end
      if (gf || gd) begin
         m_phase = 1; m_fetch = gf; m_drop = gf && if_flush;
         m_we    = gf ? 1'b0 : d_we;
         m_addr  = gf ? if_addr : d_addr;
         m_wdata = gf ? '0 : d_wdata;
         m_be    = gf ? 4'hF : d_be;
         if (gf) begin m_starve = 0; if_done = 1; end
         else begin
            d_done = 1;
            if (if_req && m_starve < SL) m_starve++;
         end
      end
   endtask

   // Scoreboard monitor: every response pulse is matched against the oldest expectation.
   always @(negedge clk) begin
      if (!reset && sb_on) begin
         if (if_rvalid && d_rvalid) chk("rv_overlap", 64'(1), 64'(0));
         if (if_rvalid || d_rvalid) begin
            if (exp_q.size() == 0) chk("rv_unexpected", 64'(1), 64'(0));
            else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("rv_owner", 64'(if_rvalid), 64'(e.fetch));
               chk("rv_data", 64'(if_rvalid ? if_rdata : d_rdata), 64'(e.data));
               chk("rv_cycle", 64'(cyc), 64'(e.due));
            end
         end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            chk("rv_missing", 64'(1), 64'(0));
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      for (int i = 0; i < 16; i++) begin
         ref_mem[i] = $urandom();
         mac_mem[i] = ref_mem[i];
      end
      // Reset state, with both requests asserted during reset
      reset = 1; if_req = 1; d_req = 1;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_if_gnt", 64'(if_gnt), 64'(0));
      chk("rst_d_gnt", 64'(d_gnt), 64'(0));
      chk("rst_mem_req", 64'(mem_req), 64'(0));
      chk("rst_rvalid", 64'({if_rvalid, d_rvalid}), 64'(0));
      chk("rst_rdata", 64'({if_rdata, d_rdata}), 64'(0));
      chk("rst_mem_fields", 64'({mem_we, mem_be, mem_addr}), 64'(0));
      @(posedge clk); #1;
      reset = 0; if_req = 0; d_req = 0;

      // Lone fetch at minimum latency
      @(posedge clk); #1;
      if_req = 1; if_addr = 32'h40; mem_ready = 1;
      #1;
      chk("lf_if_gnt", 64'(if_gnt), 64'(1));
      chk("lf_d_gnt", 64'(d_gnt), 64'(0));
      @(posedge clk); #1;
      if_req = 0;
      #1;
      chk("lf_mem_req", 64'(mem_req), 64'(1));
      chk("lf_mem_addr", 64'(mem_addr), 64'h40);
      chk("lf_mem_be", 64'(mem_be), 64'hF);
      chk("lf_mem_we", 64'(mem_we), 64'(0));
      @(posedge clk); #1;
      mem_ready = 0; mem_rvalid = 1; mem_rdata = 32'h0050_0093;
      #1;
      chk("lf_mem_req_low", 64'(mem_req), 64'(0));
      chk("lf_rvalid_early", 64'(if_rvalid), 64'(0));
      @(posedge clk); #1;
      mem_rvalid = 0;
      #1;
      chk("lf_if_rvalid", 64'(if_rvalid), 64'(1));
      chk("lf_if_rdata", 64'(if_rdata), 64'h0050_0093);
      @(posedge clk); #2;
      chk("lf_if_rvalid_pulse", 64'(if_rvalid), 64'(0));

      // Store under backpressure, then reset while waiting for the response
      @(posedge clk); #1;
      d_req = 1; d_we = 1; d_addr = 32'h104; d_wdata = 32'hDEAD_BEEF; d_be = 4'h3; mem_ready = 0;
      #1;
      chk("bp_d_gnt", 64'(d_gnt), 64'(1));
      chk("bp_if_gnt", 64'(if_gnt), 64'(0));
      @(posedge clk); #1;
      d_req = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_mem_req", 64'(mem_req), 64'(1));
         chk("bp_fields", 64'({mem_we, mem_be, mem_addr}), {27'd0, 1'b1, 4'h3, 32'h104});
         chk("bp_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
         @(posedge clk); #1;
      end
      mem_ready = 1;
      @(posedge clk); #1;
      mem_ready = 0; reset = 1;
      @(posedge clk); #1;
      reset = 0; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
      #1;
      chk("wr_outputs", 64'({mem_req, mem_we, mem_be, if_gnt, d_gnt, if_rvalid, d_rvalid}), 64'(0));
      chk("wr_mem_addr", 64'(mem_addr), 64'(0));
      @(posedge clk); #1;
      mem_rvalid = 0;
      #1;
      chk("wr_no_rvalid", 64'({if_rvalid, d_rvalid, mem_req}), 64'(0));
      if_req = 1; if_addr = 32'h80;
      #1;
      chk("wr_idle_gnt", 64'(if_gnt), 64'(1));

      // Randomized traffic: mixed, saturated (starvation), flush-heavy, then drain
      do_reset();
      sb_on = 1;
      repeat (1500) step(50, 50, 60, 10);
      repeat (600)  step(100, 100, 80, 0);
      repeat (800)  step(80, 25, 50, 40);
      repeat (40)   step(0, 0, 100, 0);
      @(negedge clk);
      chk("sb_drained", 64'(exp_q.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
